// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 frame constants, byte type and frame check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam int   FRAME_BITS  = 11;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;
    localparam int   SYNC_STAGES = 3;

    typedef logic [7:0] ps2_byte_t;

    // body holds start, 8 data bits and parity; stop is the bit arriving now.
    // Odd parity means data plus parity must carry an odd number of ones.
    function automatic logic frame_ok(input logic [FRAME_BITS-2:0] body,
                                      input logic                  stop);
        return (body[0] == START_BIT) && (stop == STOP_BIT) &&
               (^body[FRAME_BITS-2:1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_fifo
// Description : Circular byte FIFO for received scan codes. One slot is kept
//               free to tell full from empty; sticky overflow on a dropped push.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clr,
    input  logic      push,
    input  ps2_byte_t din,
    input  logic      pop,
    output ps2_byte_t dout,
    output logic      ready,
    output logic      full,
    output logic      overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ps2_byte_t     mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic          overflow_q;
    logic          do_pop;
    logic          do_push;

    assign ready    = (wptr_q != rptr_q);
    assign full     = ((wptr_q + AW'(1)) == rptr_q);
    // A pop on an empty FIFO is ignored, so only a real pop can make room.
    assign do_pop   = pop & ready;
    assign do_push  = push & (~full | do_pop);
    assign dout     = mem_q[rptr_q];
    assign overflow = overflow_q;

    // Pointer and sticky overflow update; flush discards same-cycle traffic.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (push && !do_push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage array; contents are not reset, only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !clr && !rst) begin
            mem_q[wptr_q] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ps2_receiver
// Description : PS/2 device-to-host receiver. Synchronises the raw lines,
//               deframes 11-bit frames on ps2_clk falling edges, aborts stale
//               partial frames and queues good bytes in a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 50000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata,
    input  logic       clr,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int IW = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] ck_s_q;
    logic [SYNC_STAGES-1:0] dt_s_q;
    logic [3:0]             cnt_q;
    logic [FRAME_BITS-2:0]  buffer_q;
    logic [IW-1:0]          idle_q;
    logic                   frame_err_q;

    logic                   fe;
    logic                   bit_in;
    logic                   frame_done;
    logic                   frame_valid;
    logic                   push;
    logic                   fifo_full_unused;

    // Falling edge seen between the two oldest stages; data is taken from the
    // stage that lines up with the same ps2_clk sample.
    assign fe          = ck_s_q[SYNC_STAGES-1] & ~ck_s_q[SYNC_STAGES-2];
    assign bit_in      = dt_s_q[SYNC_STAGES-2];
    assign frame_done  = fe && (cnt_q == 4'(FRAME_BITS - 1));
    assign frame_valid = frame_ok(buffer_q, bit_in);
    assign push        = frame_done & frame_valid;
    assign frame_err   = frame_err_q;

    // Metastability chains for the asynchronous PS/2 lines; idle bus is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            ck_s_q <= '1;
            dt_s_q <= '1;
        end else begin
            ck_s_q <= {ck_s_q[SYNC_STAGES-2:0], ps2_clk};
            dt_s_q <= {dt_s_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Bit collection, stop-bit check and idle timeout of a partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            buffer_q    <= '0;
            idle_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_done & ~frame_valid;
            if (fe) begin
                idle_q <= '0;
                if (frame_done) begin
                    cnt_q <= '0;
                end else begin
                    buffer_q[cnt_q] <= bit_in;
                    cnt_q           <= cnt_q + 4'd1;
                end
            end else if (cnt_q == '0) begin
                idle_q <= '0;
            end else if (idle_q == IW'(TIMEOUT)) begin
                // Device went quiet mid-frame: resynchronise on the next start.
                cnt_q  <= '0;
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + IW'(1);
            end
        end
    end

    ps2_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .push     (push),
        .din      (buffer_q[8:1]),
        .pop      (nextdata),
        .dout     (data),
        .ready    (ready),
        .full     (fifo_full_unused),
        .overflow (overflow)
    );

endmodule
`default_nettype wire

// File: tb/tb_ps2_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_receiver
// Description : Self-checking bench for ps2_receiver. A PS/2 bus model sends
//               frames; a queue-based model predicts FIFO contents, overflow
//               and the number of frame_err cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_receiver;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 300;
    localparam int HALF    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata;
    logic       clr;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    ps2_receiver #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata  (nextdata),
        .clr       (clr),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;
    int         exp_err  = 0;
    int         seen_err = 0;
    logic       lat_before;
    logic       lat_after;

    // Every high cycle of frame_err is counted; each bad frame must add one.
    always @(negedge clk) begin
        if (frame_err === 1'b1) seen_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive the first nbits of a frame; optionally pulse nextdata so that the
    // pop lands on the same clk edge as the stop-bit push.
    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic bad_start, input logic bad_stop,
                              input int nbits, input logic pop_at_stop);
        logic [10:0] f;
        f[0]   = bad_start;
        f[8:1] = b;
        f[9]   = (~^b) ^ bad_par;
        f[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1 lat_before = ready;
            @(negedge clk);
            nextdata = (i == 10) && pop_at_stop;
            @(posedge clk);
            #1 lat_after = ready;
            @(negedge clk);
            nextdata = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic valid, input logic pop_req);
        logic did_pop;
        did_pop = pop_req && (model_q.size() > 0);
        if (!valid) exp_err++;
        else if ((model_q.size() < DEPTH - 1) || did_pop) model_q.push_back(b);
        else model_ovf = 1'b1;
        if (did_pop) void'(model_q.pop_front());
    endtask

    task automatic tx(input logic [7:0] b, input logic bad_par, input logic bad_start,
                      input logic bad_stop, input logic pop_at_stop);
        send_frame(b, bad_par, bad_start, bad_stop, 11, pop_at_stop);
        model_frame(b, !(bad_par || bad_start || bad_stop), pop_at_stop);
    endtask

    task automatic pop_n(input int n);
        nextdata = 1'b1;
        repeat (n) @(negedge clk);
        nextdata = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (model_q.size() > 0) void'(model_q.pop_front());
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".ready"}, ready, (model_q.size() != 0));
        chk({tag, ".ovf"}, overflow, model_ovf);
        if (model_q.size() != 0) chk({tag, ".data"}, data, model_q[0]);
        chk({tag, ".ferr"}, seen_err, exp_err);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         sel;
        int         npop;
        logic       bp, bs, bt, pa;

        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        nextdata = 1'b0;
        clr      = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset.ready", ready, 1'b0);
        chk("reset.ovf", overflow, 1'b0);
        chk("reset.ferr", frame_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame with latency check on the stop bit.
        tx(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("single.lat2", lat_before, 1'b0);
        chk("single.lat3", lat_after, 1'b1);
        check_state("single");
        pop_n(1);
        check_state("single.pop");

        // Parity error, then a good frame.
        tx(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        check_state("parity");
        tx(8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("parity.next");
        pop_n(1);

        // Ordering.
        tx(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("order.1");
        tx(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("order.2");
        pop_n(1);
        check_state("order.pop1");
        pop_n(1);
        check_state("order.pop2");

        // Overflow: eight frames into seven usable slots.
        for (int i = 0; i < 8; i++) tx(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("ovf8");
        do_clr();
        check_state("clr");

        // Fill, then pop in the same cycle as the next push.
        for (int i = 0; i < 7; i++) tx(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("full7");
        tx(8'h47, 1'b0, 1'b0, 1'b0, 1'b1);
        check_state("popfull");
        while (model_q.size() > 0) begin
            pop_n(1);
            check_state("drain");
        end

        // Timeout of a partial frame.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        repeat (TIMEOUT + 20) @(negedge clk);
        tx(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("timeout");
        pop_n(1);

        // Randomised frames, errors and pops.
        for (int k = 0; k < 24; k++) begin
            b   = 8'($urandom);
            bp  = 1'b0; bs = 1'b0; bt = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                sel = $urandom_range(0, 2);
                bp  = (sel == 0);
                bs  = (sel == 1);
                bt  = (sel == 2);
            end
            pa = ($urandom_range(0, 3) == 0);
            tx(b, bp, bs, bt, pa);
            check_state("rand.frame");
            npop = $urandom_range(0, 2);
            if (npop > 0) begin
                pop_n(npop);
                check_state("rand.pop");
            end
        end

        // Reset in the middle of a frame.
        tx(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("prerst.ready", ready, 1'b1);
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, 6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("inrst.ready", ready, 1'b0);
        chk("inrst.ovf", overflow, 1'b0);
        chk("inrst.ferr", frame_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        tx(8'h29, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("rstframe");
        chk("rstframe.count", model_q.size(), 1);
        pop_n(1);
        check_state("rstframe.pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_receiver.md
# ps2_receiver

PS/2 device-to-host receiver with an output FIFO. Samples the raw `ps2_clk`/`ps2_data` lines and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop). Valid bytes go into a small circular FIFO. Sits directly upstream of the keyboard scan-code decoder, which consumes `data`/`ready`/`overflow` and drives `nextdata`/`clr`.

## Interface

Parameters:
- `DEPTH`, 8: FIFO slots, power of 2; usable capacity is `DEPTH-1`.
- `TIMEOUT`, 50000: clk cycles without a ps2_clk falling edge before a partial frame is aborted.

Ports:
- `clk` in 1: system clock; all state on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous.
- `ps2_data` in 1: raw PS/2 data, asynchronous.
- `nextdata` in 1: pop request; one pop per cycle high.
- `clr` in 1: synchronous FIFO flush and overflow clear.
- `data` out 8: FIFO head byte, combinational from `mem[rptr]`.
- `ready` out 1: FIFO non-empty, `wptr != rptr`.
- `overflow` out 1: sticky; a valid frame was dropped because the FIFO was full.
- `frame_err` out 1: one-cycle pulse when a completed frame fails start/parity/stop check.

## Operation

Synchronizer:
- `ps2_clk` and `ps2_data` each pass through a 3-flop chain, `ck_s[2:0]` and `dt_s[2:0]`.
- Falling edge `fe = ck_s[2] & ~ck_s[1]`.
- Sampled bit is `dt_s[1]`, aligned with `fe`.

Deframer:
- 4-bit `cnt` (0..10) and 10-bit `buffer`.
- On `fe` with `cnt<10`: `buffer[cnt] <= bit`, `cnt <= cnt+1`.
- On `fe` with `cnt==10`, the incoming bit is the stop bit. The frame is valid iff `buffer[0]==0`, `bit==1`, and `^buffer[9:1]==1` (odd parity).
  - Valid: push `buffer[8:1]`.
  - Invalid: no push; pulse `frame_err`.
  - Either way, `cnt <= 0`.
- Idle counter increments each cycle while `cnt!=0` and no `fe`; it clears on `fe` or when `cnt==0`.
- When the idle counter reaches `TIMEOUT`: `cnt <= 0`, partial frame discarded, no `frame_err`.

FIFO:
- `DEPTH` x 8 memory, `wptr`/`rptr` of width log2(DEPTH), both wrap modulo DEPTH.
- full = `wptr+1 == rptr`.
- Push: `mem[wptr] <= byte`, `wptr++`.
  - If full and no pop in the same cycle, the byte is dropped and `overflow <= 1`.
  - If full with a pop in the same cycle, the push is accepted.
- Pop: `nextdata & ready` → `rptr++`. `nextdata` while empty is ignored.
- Simultaneous push and pop on an empty FIFO: push accepted; pop ignored, since `ready` was 0.
- `clr`: `wptr<=0`, `rptr<=0`, `overflow<=0`. Any same-cycle push or pop is discarded. Deframer state is untouched, so a frame in flight is still received after `clr`.
- `overflow` stays 1 until `clr` or `rst`. Pushes continue to be accepted once space frees.

Reset (`rst`):
- All pointers, `cnt`, idle counter, `buffer` and `overflow` go to 0; `frame_err` goes to 0.
- Sync chains go to 3'b111.
- Outputs after reset: `ready=0`, `overflow=0`, `frame_err=0`; `data = mem[0]`, content unspecified.
- `rst` mid-frame discards the partial frame.

## Timing

- First clk edge E at which `ps2_clk` is sampled low: `fe` is true during E+1..E+2, and the bit is captured at edge E+2.
- For the stop bit, the push happens at E+2, so `ready`/`data` are valid in the cycle after E+2 (latency 3 edges from first low sample).
- `frame_err` is high for exactly the cycle after E+2 of the stop bit.
- Pop at edge P:
  - `data` shows the next entry after P.
  - `ready` drops after P if that was the last entry.
- Decoder protocol: it pulses `nextdata` for one cycle, then idles one cycle. The receiver requires no idle cycle and supports back-to-back pops.
- Edge rate: PS/2 clock ≤ 16.7 kHz, with clk ≥ 1 MHz, gives ≥ 30 clk per half-period. No edge is missed provided each ps2_clk level lasts ≥ 2 clk.

## Structure

- `ps2_pkg`: `FRAME_BITS=11`, `START_BIT=0`, `STOP_BIT=1`, `SYNC_STAGES=3`, and a `ps2_byte_t` 8-bit typedef.
- Sub-module `ps2_fifo`: parameterised by `DEPTH`; ports `clk`, `rst`, `clr`, `push`, `din`, `pop`, `dout`, `ready`, `full`, `overflow`.
- `ps2_receiver` holds the synchronizers, deframer and timeout counter.

## Test plan

- **Single frame:** bus-model frame with byte 0x1C, parity bit 0 → `ready=1`, `data=0x1C` 3 edges after the stop-bit fall; `nextdata` pulse → `ready=0`, `frame_err` never set.
- **Parity error:** byte 0x1C with parity bit 1 → no push, `ready` stays 0, `frame_err` pulses for one cycle. Next valid frame 0x32 is received.
- **Ordering:** frames 0xF0 then 0x1C → pop order 0xF0, 0x1C. `data` changes only after each pop.
- **Overflow:**
  - Push 8 frames with DEPTH=8 → first 7 stored, `overflow=1`, `data` still first byte.
  - Pop at full in the same cycle as a stop-bit push → push accepted, `overflow` unchanged.
  - `clr` → `ready=0`, `overflow=0`.
- **Timeout:** 5 bits then idle > `TIMEOUT` cycles, then a full frame 0x5A → `data=0x5A`, no `frame_err`.
- **Reset mid-frame:** assert `rst` after 6 bits, release, send 0x29 → exactly one entry 0x29. Outputs read 0 during `rst`.
